// File: rtl/pcpi_pkg.sv
// pcpi_pkg: shared decode constants and enums for the PCPI coprocessor hub.
// Holds the FSM state encoding and the coprocessor target select.
package pcpi_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE,
    TMO
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    MUL,
    DIV
  } tgt_e;

  function automatic tgt_e decode(input logic [31:0] insn);
    tgt_e t;
    t = NONE;
    if (insn[6:0] == OPC_OP && insn[31:25] == F7_MULDIV)
      t = insn[14] ? DIV : MUL;
    return t;
  endfunction

endpackage

// File: rtl/pcpi_hub_if.sv
// pcpi_hub_if: CPU-side PCPI request/response bundle.
// master drives requests, slave returns results.
interface pcpi_hub_if;

  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        pcpi_timeout;

  modport master (
    output pcpi_valid,
    output pcpi_insn,
    output pcpi_rs1,
    output pcpi_rs2,
    input  pcpi_wr,
    input  pcpi_rd,
    input  pcpi_wait,
    input  pcpi_ready,
    input  pcpi_timeout
  );

  modport slave (
    input  pcpi_valid,
    input  pcpi_insn,
    input  pcpi_rs1,
    input  pcpi_rs2,
    output pcpi_wr,
    output pcpi_rd,
    output pcpi_wait,
    output pcpi_ready,
    output pcpi_timeout
  );

endinterface

// File: rtl/pcpi_timeout_ctr.sv
// pcpi_timeout_ctr: counts idle issue cycles; tc flags the cycle whose
// increment would reach TC-1, so the owner can leave on that edge.
module pcpi_timeout_ctr #(
  parameter int unsigned TC = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic inc,
  input  logic clr,
  output logic tc
);

  localparam logic [7:0] LAST = 8'(TC - 2);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tc = inc & ~clr & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tc)
      cnt_d = '0;
    else if (inc)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pcpi_hub.sv
// pcpi_hub: routes PCPI requests to a multiplier or divider coprocessor.
// Issue timeout compiled in with PCPI_HUB_TIMEOUT_EN.
module pcpi_hub
  import pcpi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        pcpi_timeout,
  output logic [31:0] c_insn,
  output logic [31:0] c_rs1,
  output logic [31:0] c_rs2,
  output logic        mul_valid,
  output logic        div_valid,
  input  logic        mul_wr,
  input  logic [31:0] mul_rd,
  input  logic        mul_wait,
  input  logic        mul_ready,
  input  logic        div_wr,
  input  logic [31:0] div_rd,
  input  logic        div_wait,
  input  logic        div_ready
);

  state_e      state_q, state_d;
  tgt_e        tgt_q, tgt_d;
  logic [31:0] c_insn_q, c_insn_d;
  logic [31:0] c_rs1_q, c_rs1_d;
  logic [31:0] c_rs2_q, c_rs2_d;
  logic [31:0] rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        hold_q, hold_d;

  tgt_e        dec;
  logic        take;
  logic        sel_wait;
  logic        sel_ready;
  logic        sel_wr;
  logic [31:0] sel_rd;

  assign dec = decode(pcpi_insn);

`ifdef PCPI_HUB_TIMEOUT_EN
  logic tc;
  logic cnt_inc;
  logic cnt_clr;

  assign take    = 1'b1;
  assign cnt_inc = (state_q == ISSUE) & ~sel_wait & ~sel_ready;
  assign cnt_clr = (state_q != ISSUE) | sel_wait | sel_ready;

  pcpi_timeout_ctr #(
    .TC (TIMEOUT_CYCLES)
  ) u_ctr (
    .clk    (clk),
    .resetn (resetn),
    .inc    (cnt_inc),
    .clr    (cnt_clr),
    .tc     (tc)
  );
`else
  // Nothing could ever answer a NONE request, so it is never accepted.
  assign take = (dec != NONE);
`endif

  always_comb begin
    sel_wait  = 1'b0;
    sel_ready = 1'b0;
    sel_wr    = 1'b0;
    sel_rd    = '0;
    unique case (1'b1)
      tgt_q == MUL: begin
        sel_wait  = mul_wait;
        sel_ready = mul_ready;
        sel_wr    = mul_wr;
        sel_rd    = mul_rd;
      end
      tgt_q == DIV: begin
        sel_wait  = div_wait;
        sel_ready = div_ready;
        sel_wr    = div_wr;
        sel_rd    = div_rd;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    c_insn_d = c_insn_q;
    c_rs1_d  = c_rs1_q;
    c_rs2_d  = c_rs2_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    hold_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pcpi_valid && !hold_q && take) begin
          c_insn_d = pcpi_insn;
          c_rs1_d  = pcpi_rs1;
          c_rs2_d  = pcpi_rs2;
          tgt_d    = dec;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (sel_ready) begin
          rd_d    = sel_rd;
          wr_d    = sel_wr;
          state_d = DONE;
        end
`ifdef PCPI_HUB_TIMEOUT_EN
        else if (tc) begin
          state_d = TMO;
        end
`endif
      end
      DONE: begin
        hold_d  = 1'b1;
        state_d = IDLE;
      end
      TMO: begin
        hold_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      tgt_q    <= NONE;
      c_insn_q <= '0;
      c_rs1_q  <= '0;
      c_rs2_q  <= '0;
      rd_q     <= '0;
      wr_q     <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      c_insn_q <= c_insn_d;
      c_rs1_q  <= c_rs1_d;
      c_rs2_q  <= c_rs2_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      hold_q   <= hold_d;
    end
  end

  assign c_insn     = c_insn_q;
  assign c_rs1      = c_rs1_q;
  assign c_rs2      = c_rs2_q;
  assign mul_valid  = (state_q == ISSUE) && (tgt_q == MUL);
  assign div_valid  = (state_q == ISSUE) && (tgt_q == DIV);
  assign pcpi_wait  = (state_q == ISSUE) && sel_wait;
  assign pcpi_ready = (state_q == DONE);
  assign pcpi_rd    = pcpi_ready ? rd_q : 32'd0;
  assign pcpi_wr    = pcpi_ready & wr_q;

`ifdef PCPI_HUB_TIMEOUT_EN
  assign pcpi_timeout = (state_q == TMO);
`else
  assign pcpi_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pcpi_hub.sv
// tb_pcpi_hub: randomized self-checking bench for pcpi_hub.
// Expectations come from a transaction-level latency/decode model.
`timescale 1ns/1ps
module tb_pcpi_hub;

  localparam int TMO_N = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] c_insn, c_rs1, c_rs2;
  logic        mul_valid, div_valid;
  logic        mul_wr, mul_wait, mul_ready;
  logic        div_wr, div_wait, div_ready;
  logic [31:0] mul_rd, div_rd;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  pcpi_hub_if cpu ();

  pcpi_hub #(
    .TIMEOUT_CYCLES (TMO_N)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pcpi_valid   (cpu.pcpi_valid),
    .pcpi_insn    (cpu.pcpi_insn),
    .pcpi_rs1     (cpu.pcpi_rs1),
    .pcpi_rs2     (cpu.pcpi_rs2),
    .pcpi_wr      (cpu.pcpi_wr),
    .pcpi_rd      (cpu.pcpi_rd),
    .pcpi_wait    (cpu.pcpi_wait),
    .pcpi_ready   (cpu.pcpi_ready),
    .pcpi_timeout (cpu.pcpi_timeout),
    .c_insn       (c_insn),
    .c_rs1        (c_rs1),
    .c_rs2        (c_rs2),
    .mul_valid    (mul_valid),
    .div_valid    (div_valid),
    .mul_wr       (mul_wr),
    .mul_rd       (mul_rd),
    .mul_wait     (mul_wait),
    .mul_ready    (mul_ready),
    .div_wr       (div_wr),
    .div_rd       (div_rd),
    .div_wait     (div_wait),
    .div_ready    (div_ready)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_stubs;
    mul_wr = 0; mul_rd = 0; mul_wait = 0; mul_ready = 0;
    div_wr = 0; div_rd = 0; div_wait = 0; div_ready = 0;
  endtask

  // 0 = none, 1 = multiplier, 2 = divider
  function automatic int model_tgt(input logic [31:0] insn);
    logic [6:0] op, f7;
    logic [2:0] f3;
    op = insn[6:0];
    f7 = insn[31:25];
    f3 = insn[14:12];
    if (op != 7'h33 || f7 != 7'h01) return 0;
    return (f3 >= 3'd4) ? 2 : 1;
  endfunction

  // Drives one request starting in the current cycle (cycle 0) with the
  // selected stub answering k cycles after valid rises.  Returns the cycle
  // pcpi_ready was seen (or -1) and a count of per-cycle protocol slips.
  task automatic do_txn(
    input  logic [31:0] insn, rs1, rs2,
    input  int          k,
    input  bit          use_wait,
    input  logic [31:0] rd,
    input  bit          wr,
    input  bit          hold,
    output int          lat,
    output logic [31:0] got_rd,
    output bit          got_wr,
    output int          bad
  );
    int          tgt;
    bit          rdy, wt, iss;
    logic [31:0] junk, j2;
    tgt = model_tgt(insn);
    lat = -1; bad = 0; got_rd = 0; got_wr = 0;
    cpu.pcpi_valid = 1;
    cpu.pcpi_insn  = insn;
    cpu.pcpi_rs1   = rs1;
    cpu.pcpi_rs2   = rs2;
    tick();
    if (!hold) begin
      cpu.pcpi_valid = 0;
      cpu.pcpi_insn  = $urandom;
      cpu.pcpi_rs1   = $urandom;
      cpu.pcpi_rs2   = $urandom;
    end
    for (int cyc = 1; cyc <= 100 && lat < 0; cyc++) begin
      rdy  = (cyc == 1 + k);
      wt   = use_wait && (cyc < 1 + k);
      iss  = (cyc <= 1 + k);
      junk = $urandom;
      j2   = $urandom;
      if (tgt == 1) begin
        mul_ready = rdy; mul_wait = wt;
        mul_rd = rdy ? rd : junk; mul_wr = rdy ? wr : junk[0];
        div_ready = j2[0]; div_wait = j2[1]; div_wr = j2[2]; div_rd = $urandom;
      end else begin
        div_ready = rdy; div_wait = wt;
        div_rd = rdy ? rd : junk; div_wr = rdy ? wr : junk[0];
        mul_ready = j2[0]; mul_wait = j2[1]; mul_wr = j2[2]; mul_rd = $urandom;
      end
      #1;
      if (mul_valid !== (iss && tgt == 1)) bad++;
      if (div_valid !== (iss && tgt == 2)) bad++;
      if (cpu.pcpi_wait !== wt) bad++;
      if (cpu.pcpi_timeout !== 1'b0) bad++;
      if (c_insn !== insn || c_rs1 !== rs1 || c_rs2 !== rs2) bad++;
      if (cpu.pcpi_ready === 1'b1) begin
        lat    = cyc;
        got_rd = cpu.pcpi_rd;
        got_wr = cpu.pcpi_wr;
      end else if (cpu.pcpi_rd !== 32'd0 || cpu.pcpi_wr !== 1'b0) begin
        bad++;
      end
      if (lat < 0) tick();
    end
    quiet_stubs();
  endtask

  task automatic test_reset;
    resetn = 0;
    tick();
    tick();
    n_chk++;
    if ({c_insn, c_rs1, c_rs2} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_c: got %h %h %h required 0", c_insn, c_rs1, c_rs2);
    end
    n_chk++;
    if ({mul_valid, div_valid, cpu.pcpi_ready, cpu.pcpi_wait,
         cpu.pcpi_timeout, cpu.pcpi_wr} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 000000",
               {mul_valid, div_valid, cpu.pcpi_ready, cpu.pcpi_wait,
                cpu.pcpi_timeout, cpu.pcpi_wr});
    end
    n_chk++;
    if (cpu.pcpi_rd !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_rd: got %h required 0", cpu.pcpi_rd);
    end
    resetn = 1;
    tick();
  endtask

  task automatic test_mul;
    int lat, bad; logic [31:0] rd; bit wr;
    do_txn(32'h02B50533, 32'd7, 32'd6, 2, 0, 32'd42, 1, 0, lat, rd, wr, bad);
    n_chk++;
    if (lat !== 4) begin n_fail++; $display("FAIL mul_lat: got %0d required 4", lat); end
    n_chk++;
    if (rd !== 32'd42 || wr !== 1'b1) begin
      n_fail++; $display("FAIL mul_rd: got %0d/%b required 42/1", rd, wr);
    end
    n_chk++;
    if (bad !== 0) begin n_fail++; $display("FAIL mul_proto: got %0d slips required 0", bad); end
    tick();
    n_chk++;
    if (cpu.pcpi_ready !== 1'b0 || cpu.pcpi_rd !== 32'd0) begin
      n_fail++;
      $display("FAIL mul_once: got ready=%b rd=%h required 0/0", cpu.pcpi_ready, cpu.pcpi_rd);
    end
    tick();
  endtask

  task automatic test_div;
    int lat, bad; logic [31:0] rd; bit wr;
    do_txn(32'h02B54533, 32'd100, 32'd0, 30, 1, 32'hFFFFFFFF, 1, 0, lat, rd, wr, bad);
    n_chk++;
    if (lat !== 32) begin n_fail++; $display("FAIL div_lat: got %0d required 32", lat); end
    n_chk++;
    if (rd !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_rd: got %h required ffffffff", rd); end
    n_chk++;
    if (bad !== 0) begin n_fail++; $display("FAIL div_proto: got %0d slips required 0", bad); end
    tick();
    n_chk++;
    if (cpu.pcpi_rd !== 32'd0) begin
      n_fail++; $display("FAIL div_once: got %h required 0", cpu.pcpi_rd);
    end
    tick();
  endtask

  task automatic test_timeout;
    logic [31:0] c_prev;
    int first, cnt, rdy_seen, v_seen;
    c_prev = c_insn;
    first = -1; cnt = 0; rdy_seen = 0; v_seen = 0;
    cpu.pcpi_valid = 1;
    cpu.pcpi_insn  = 32'h00000013;
    tick();
    cpu.pcpi_valid = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cpu.pcpi_timeout === 1'b1) begin
        cnt++;
        if (first < 0) first = cyc;
      end
      if (cpu.pcpi_ready !== 1'b0) rdy_seen++;
      if (mul_valid !== 1'b0 || div_valid !== 1'b0) v_seen++;
      tick();
    end
`ifdef PCPI_HUB_TIMEOUT_EN
    n_chk++;
    if (first !== 16 || cnt !== 1) begin
      n_fail++; $display("FAIL tmo_pulse: got at %0d x%0d required at 16 x1", first, cnt);
    end
    n_chk++;
    if (c_insn !== 32'h00000013) begin
      n_fail++; $display("FAIL tmo_capture: got %h required 00000013", c_insn);
    end
`else
    n_chk++;
    if (cnt !== 0) begin
      n_fail++; $display("FAIL tmo_pulse: got %0d timeout cycles required 0", cnt);
    end
    n_chk++;
    if (c_insn !== c_prev) begin
      n_fail++; $display("FAIL tmo_capture: got %h required %h", c_insn, c_prev);
    end
`endif
    n_chk++;
    if (rdy_seen !== 0 || v_seen !== 0) begin
      n_fail++; $display("FAIL tmo_quiet: got ready %0d valid %0d required 0/0", rdy_seen, v_seen);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bad, stray; logic [31:0] rd; bit wr;
    cpu.pcpi_valid = 1;
    cpu.pcpi_insn  = 32'h02B50533;
    cpu.pcpi_rs1   = 32'h11;
    cpu.pcpi_rs2   = 32'h22;
    tick();
    cpu.pcpi_valid = 0;
    mul_wait = 1;
    tick();
    tick();
    resetn = 0;
    tick();
    n_chk++;
    if ({c_insn, c_rs1, c_rs2, cpu.pcpi_rd} !== 128'd0 ||
        {mul_valid, div_valid, cpu.pcpi_ready, cpu.pcpi_wait,
         cpu.pcpi_timeout, cpu.pcpi_wr} !== 6'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got c=%h valid=%b%b rdy=%b wait=%b tmo=%b required all 0",
               c_insn, mul_valid, div_valid, cpu.pcpi_ready, cpu.pcpi_wait, cpu.pcpi_timeout);
    end
    tick();
    resetn = 1;
    mul_wait = 0;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cpu.pcpi_ready !== 1'b0 || cpu.pcpi_timeout !== 1'b0) stray++;
    end
    n_chk++;
    if (stray !== 0) begin n_fail++; $display("FAIL rst_silent: got %0d stray cycles required 0", stray); end
    do_txn(32'h02B50533, 32'd3, 32'd5, 3, 0, 32'd15, 1, 0, lat, rd, wr, bad);
    n_chk++;
    if (lat !== 5 || rd !== 32'd15 || bad !== 0) begin
      n_fail++; $display("FAIL rst_after: got lat %0d rd %0d slips %0d required 5/15/0", lat, rd, bad);
    end
    tick();
    tick();
  endtask

  task automatic test_race;
    int lat, bad; logic [31:0] rd; bit wr;
    do_txn(32'h02B50533, 32'd9, 32'd9, TMO_N - 2, 0, 32'd81, 0, 0, lat, rd, wr, bad);
    n_chk++;
    if (lat !== TMO_N || rd !== 32'd81) begin
      n_fail++; $display("FAIL race: got lat %0d rd %0d required %0d/81", lat, rd, TMO_N);
    end
    n_chk++;
    if (bad !== 0) begin n_fail++; $display("FAIL race_proto: got %0d slips required 0", bad); end
    tick();
    tick();
  endtask

  task automatic test_back_to_back;
    int lat, bad; logic [31:0] rd; bit wr;
    logic [31:0] a, b;
    a = 32'h02C58633;
    b = 32'h02C5C633;
    do_txn(a, 32'd20, 32'd3, 1, 0, 32'd60, 1, 1, lat, rd, wr, bad);
    n_chk++;
    if (lat !== 3 || rd !== 32'd60 || bad !== 0) begin
      n_fail++; $display("FAIL b2b_first: got lat %0d rd %0d slips %0d required 3/60/0", lat, rd, bad);
    end
    tick();
    n_chk++;
    if (mul_valid !== 1'b0 || div_valid !== 1'b0 || c_insn !== a) begin
      n_fail++; $display("FAIL b2b_holdoff: got valid %b%b c %h required 00 %h",
                         mul_valid, div_valid, c_insn, a);
    end
    tick();
    n_chk++;
    if (mul_valid !== 1'b0 || c_insn !== a) begin
      n_fail++; $display("FAIL b2b_idle: got valid %b c %h required 0 %h", mul_valid, c_insn, a);
    end
    do_txn(b, 32'd20, 32'd3, 2, 0, 32'd6, 1, 0, lat, rd, wr, bad);
    n_chk++;
    if (lat !== 4 || rd !== 32'd6 || bad !== 0) begin
      n_fail++; $display("FAIL b2b_second: got lat %0d rd %0d slips %0d required 4/6/0", lat, rd, bad);
    end
    tick();
    tick();
  endtask

  task automatic test_random;
    int lat, bad, k; logic [31:0] rd, got, r, insn; bit wr, gwr, uw, isdiv;
    for (int i = 0; i < 8; i++) begin
      r     = $urandom;
      isdiv = r[31];
      uw    = r[30];
      insn  = {7'b0000001, r[24:15], isdiv, r[13:7], 7'b0110011};
      k     = uw ? $urandom_range(1, 40) : $urandom_range(0, 12);
      rd    = $urandom;
      wr    = r[29];
      do_txn(insn, $urandom, $urandom, k, uw, rd, wr, 0, lat, got, gwr, bad);
      n_chk++;
      if (lat !== k + 2) begin
        n_fail++; $display("FAIL rnd%0d_lat: got %0d required %0d", i, lat, k + 2);
      end
      n_chk++;
      if (got !== rd || gwr !== wr) begin
        n_fail++; $display("FAIL rnd%0d_rd: got %h/%b required %h/%b", i, got, gwr, rd, wr);
      end
      n_chk++;
      if (bad !== 0) begin
        n_fail++; $display("FAIL rnd%0d_proto: got %0d slips required 0", i, bad);
      end
      tick();
      tick();
    end
  endtask

  initial begin
    cpu.pcpi_valid = 0;
    cpu.pcpi_insn  = 0;
    cpu.pcpi_rs1   = 0;
    cpu.pcpi_rs2   = 0;
    quiet_stubs();
    test_reset();
    test_mul();
    test_div();
    test_timeout();
    test_reset_mid();
    test_race();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
